vga_out_unit: RTL and testbench
===============================

# vga_out_unit

Line-buffered VGA output stage for 800x600@60 (40 MHz pixel clock). It sits between the pixel-generation pipeline and the board VGA pins. A pixel stream addressed by hcount/vcount enters on a `vga_if` in-modport and is written into one of two ping-pong line buffers. The previous line is replayed from the other buffer with regenerated sync/blank on a `vga_if` out-modport, one line later.

## Interface
Clocking: one clock; reset is synchronous and active-high.

Parameters (defaults from `vga_pkg`):
- H_ACTIVE, 800, visible pixels per line (line buffer depth).
- HCOUNT_MAX, 1055, last hcount of a line.
- HSYNC_START / HSYNC_END, 840 / 968, hsync asserted for HSYNC_START ≤ hcount < HSYNC_END.
- V_ACTIVE, 600, visible lines.
- VCOUNT_MAX, 627, last vcount of a frame.
- VSYNC_START / VSYNC_END, 601 / 605, vsync asserted for VSYNC_START ≤ vcount < VSYNC_END.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- in  `vga_if.in`: hcount[10:0], vcount[10:0], rgb[11:0] used; sync/blank inputs ignored.
- out  `vga_if.out`: hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk, rgb[11:0].

Internal signals at module scope, hierarchically probed by verification:
- line_buffer_A, line_buffer_B: each logic [11:0] [0:H_ACTIVE-1].
- buffer_select: logic.
- frame_ready: logic.

## Operation
- Write side:
  - Condition: in.hcount < H_ACTIVE and in.vcount < V_ACTIVE.
  - Action: in.rgb is written to address in.hcount of line_buffer_A when buffer_select=0, of line_buffer_B when buffer_select=1.
  - No write otherwise.
- buffer_select:
  - Toggles on every input line end (in.hcount == HCOUNT_MAX), including blanking lines.
  - VCOUNT_MAX+1 = 628 is even, so parity per vcount is stable across frames.
- Read side:
  - Each cycle reads address in.hcount of the non-selected buffer (A when buffer_select=1, B when 0), i.e. the line written previously.
  - The read is registered into out.rgb.
  - If the address is ≥ H_ACTIVE, the read is suppressed and rgb is forced to 0.
- Output timing, delayed one line:
  - out.hcount = in.hcount.
  - out.vcount = (in.vcount == 0) ? VCOUNT_MAX : in.vcount-1.
  - Both are registered.
  - Output line v therefore displays the pixels captured on input line v.
- Sync and blank, all registered and aligned with out.hcount/out.vcount:
  - hsync and vsync decode from the output counters, positive polarity.
  - hblnk = out.hcount ≥ H_ACTIVE.
  - vblnk = out.vcount ≥ V_ACTIVE.
  - out.rgb = 12'h000 whenever hblnk or vblnk.
- frame_ready: single-cycle pulse in the cycle after the input reaches hcount == HCOUNT_MAX and vcount == VCOUNT_MAX. Exactly one pulse per frame.
- Line buffers are not reset; contents after reset are undefined until written.

## Timing
- Latency:
  - Input pixel (h, v) appears on the output at out.hcount = h, out.vcount = v.
  - This is one line period (1056 cycles) plus 1 register stage after capture.
- Write: occurs on the rising edge where the input is valid.
- Buffer swap: buffer_select flips on the edge following in.hcount == HCOUNT_MAX. Line N's last write (hcount 799) and line N+1's first write (hcount 0) go to different buffers.
- Reset values: out.hcount=0, out.vcount=0, hsync=0, vsync=0, hblnk=0, vblnk=0, out.rgb=0, buffer_select=0, frame_ready=0.
- First valid output:
  - The first frame of output after reset may show undefined buffer contents on line 0, before the first full input line has been written. This is acceptable.
  - Every subsequent line is correct.
- Reset mid-frame: all registers return to their reset values on the next edge. Buffers keep their contents and are overwritten by subsequent input.
- Wrap-around:
  - in.vcount 0 → out.vcount VCOUNT_MAX.
  - in.hcount HCOUNT_MAX → 0 with no gap cycle.

## Test plan
- Reset, 10 cycles: all outputs 0, buffer_select=0, frame_ready=0 throughout reset.
- Free-running counters 0..1055 / 0..627, in.rgb = buffer_select ? 12'hBBB : 12'hAAA, run until 3 frame_ready pulses:
  - Every line_buffer_A entry = 12'hAAA.
  - Every line_buffer_B entry = 12'hBBB.
- frame_ready counting: exactly one single-cycle pulse per 1056*628 = 663168 cycles, one cycle after in (1055, 627).
- Line replay: in.rgb = {1'b0, in.vcount[10:0]} truncated to 12 bits → on out line v < 600, out.rgb == v[11:0] for hcount 0..799, and 0 for hcount ≥ 800.
- Sync and blank checks against out counters:
  - hsync=1 exactly for out.hcount 840..967.
  - vsync=1 exactly for out.vcount 601..604.
  - hblnk=1 for out.hcount ≥ 800; vblnk=1 for out.vcount ≥ 600.
  - out.rgb=0 during any blank.
- Mid-frame reset at in (400, 300) held 1 cycle:
  - Outputs return to their reset values.
  - buffer_select=0.
  - After counters restart, correct output resumes from output line 1 onward.

Source files
------------

// File: rtl/vga_out_unit_if.sv
// vga_if: VGA timing/pixel bundle shared by the pixel pipeline and the output stage.
//   hcount/vcount : raster position
//   hsync/vsync   : sync pulses, positive polarity
//   hblnk/vblnk   : blanking flags
//   rgb           : 4:4:4 pixel colour
// Modports: in (consumer view), out (producer view).
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_out_unit.sv
// vga_pkg: 800x600@60 raster constants.
// vga_out_unit: line-buffered VGA output stage. Incoming pixels are written
// into one of two ping-pong line buffers; the other buffer (the previous
// line) is replayed one line later with regenerated sync and blanking.
// Ports:
//   clk  - pixel clock (40 MHz)
//   rst  - synchronous, active-high reset
//   in   - vga_if.in : hcount, vcount, rgb used; sync/blank ignored
//   out  - vga_if.out: delayed counters, hsync, vsync, hblnk, vblnk, rgb
package vga_pkg;
    localparam logic [10:0] H_ACTIVE    = 11'd800;
    localparam logic [10:0] HCOUNT_MAX  = 11'd1055;
    localparam logic [10:0] HSYNC_START = 11'd840;
    localparam logic [10:0] HSYNC_END   = 11'd968;
    localparam logic [10:0] V_ACTIVE    = 11'd600;
    localparam logic [10:0] VCOUNT_MAX  = 11'd627;
    localparam logic [10:0] VSYNC_START = 11'd601;
    localparam logic [10:0] VSYNC_END   = 11'd605;
endpackage

module vga_out_unit #(
    parameter logic [10:0] H_ACTIVE    = vga_pkg::H_ACTIVE,
    parameter logic [10:0] HCOUNT_MAX  = vga_pkg::HCOUNT_MAX,
    parameter logic [10:0] HSYNC_START = vga_pkg::HSYNC_START,
    parameter logic [10:0] HSYNC_END   = vga_pkg::HSYNC_END,
    parameter logic [10:0] V_ACTIVE    = vga_pkg::V_ACTIVE,
    parameter logic [10:0] VCOUNT_MAX  = vga_pkg::VCOUNT_MAX,
    parameter logic [10:0] VSYNC_START = vga_pkg::VSYNC_START,
    parameter logic [10:0] VSYNC_END   = vga_pkg::VSYNC_END
) (
    input  logic clk,
    input  logic rst,
    vga_if.in    in,
    vga_if.out   out
);
    localparam int AW = $clog2(int'(H_ACTIVE));

    logic [11:0] line_buffer_A [0:H_ACTIVE-1];
    logic [11:0] line_buffer_B [0:H_ACTIVE-1];
    logic        buffer_select;
    logic        frame_ready;

    logic [10:0] hcount_q, hcount_d;
    logic [10:0] vcount_q, vcount_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        hblnk_q, hblnk_d;
    logic        vblnk_q, vblnk_d;
    logic [11:0] rgb_q, rgb_d;

    logic          h_active;
    logic          wr_en;
    logic [AW-1:0] addr;
    logic [11:0]   rd_data;
    logic          line_end;

    // Input sync/blank are regenerated here, never consumed.
    logic unused_in_sync;
    assign unused_in_sync = ^{in.hsync, in.vsync, in.hblnk, in.vblnk};

    assign h_active = (in.hcount < H_ACTIVE);
    assign wr_en    = h_active && (in.vcount < V_ACTIVE) && !rst;
    // Clamp the address so out-of-range hcounts never index past the buffer.
    assign addr     = h_active ? in.hcount[AW-1:0] : '0;
    assign line_end = (in.hcount == HCOUNT_MAX);

    always_ff @(posedge clk) begin
        if (wr_en && !buffer_select) begin
            line_buffer_A[addr] <= in.rgb;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && buffer_select) begin
            line_buffer_B[addr] <= in.rgb;
        end
    end

    // Read side always uses the buffer not being written: the previous line.
    always_comb begin
        rd_data = 12'h000;
        if (h_active) begin
            rd_data = buffer_select ? line_buffer_A[addr] : line_buffer_B[addr];
        end
    end

    always_comb begin
        hcount_d = in.hcount;
        vcount_d = (in.vcount == 11'd0) ? VCOUNT_MAX : (in.vcount - 11'd1);
        hsync_d  = (hcount_d >= HSYNC_START) && (hcount_d < HSYNC_END);
        vsync_d  = (vcount_d >= VSYNC_START) && (vcount_d < VSYNC_END);
        hblnk_d  = (hcount_d >= H_ACTIVE);
        vblnk_d  = (vcount_d >= V_ACTIVE);
        rgb_d    = (hblnk_d || vblnk_d) ? 12'h000 : rd_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            hblnk_q       <= 1'b0;
            vblnk_q       <= 1'b0;
            rgb_q         <= '0;
            buffer_select <= 1'b0;
            frame_ready   <= 1'b0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            hblnk_q       <= hblnk_d;
            vblnk_q       <= vblnk_d;
            rgb_q         <= rgb_d;
            // Swap on every line end, blanking lines included, so the
            // buffer parity per vcount stays fixed across frames.
            if (line_end) begin
                buffer_select <= ~buffer_select;
            end
            frame_ready   <= line_end && (in.vcount == VCOUNT_MAX);
        end
    end

    assign out.hcount = hcount_q;
    assign out.vcount = vcount_q;
    assign out.hsync  = hsync_q;
    assign out.vsync  = vsync_q;
    assign out.hblnk  = hblnk_q;
    assign out.vblnk  = vblnk_q;
    assign out.rgb    = rgb_q;

endmodule

// File: tb/tb_vga_out_unit.sv
// Directed bench for vga_out_unit: drives whole input lines (vcount may jump
// between lines to reach the interesting rows quickly) and checks every
// output cycle against a reference model through a scoreboard queue.
module tb_vga_out_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;

    vga_if vin ();
    vga_if vout ();

    vga_out_unit dut (
        .clk (clk),
        .rst (rst),
        .in  (vin),
        .out (vout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [26:0] ctl;       // {hcount, vcount, hsync, vsync, hblnk, vblnk, frame_ready}
        logic [11:0] rgb;
        bit          rgb_known;
        logic        bsel;
    } exp_t;

    exp_t sbq[$];

    int total = 0;
    int bad   = 0;

    // Reference model: two line stores with per-entry written flags.
    logic [11:0] mA [0:799];
    logic [11:0] mB [0:799];
    bit          vA [0:799];
    bit          vB [0:799];
    bit          m_bsel = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input int h, input int v, input logic [11:0] pix, input bit r);
        exp_t        e;
        exp_t        got;
        logic [10:0] ovc;
        logic        hs, vs, hb, vb, fr;
        vin.hcount = 11'(h);
        vin.vcount = 11'(v);
        vin.rgb    = pix;
        rst        = r;
        if (r) begin
            e.ctl       = '0;
            e.rgb       = '0;
            e.rgb_known = 1'b1;
            e.bsel      = 1'b0;
        end else begin
            ovc = (v == 0) ? 11'd627 : 11'(v - 1);
            hs  = (h >= 840) && (h < 968);
            vs  = (ovc >= 11'd601) && (ovc < 11'd605);
            hb  = (h >= 800);
            vb  = (ovc >= 11'd600);
            fr  = (h == 1055) && (v == 627);
            e.ctl = {11'(h), ovc, hs, vs, hb, vb, fr};
            if (hb || vb) begin
                e.rgb       = '0;
                e.rgb_known = 1'b1;
            end else if (m_bsel) begin
                e.rgb       = mA[h];
                e.rgb_known = vA[h];
            end else begin
                e.rgb       = mB[h];
                e.rgb_known = vB[h];
            end
            e.bsel = (h == 1055) ? ~m_bsel : m_bsel;
        end
        sbq.push_back(e);
        @(posedge clk);
        if (!r && h < 800 && v < 600) begin
            if (m_bsel) begin
                mB[h] = pix;
                vB[h] = 1'b1;
            end else begin
                mA[h] = pix;
                vA[h] = 1'b1;
            end
        end
        m_bsel = e.bsel;
        #1;
        got = sbq.pop_front();
        chk("ctl", 64'({vout.hcount, vout.vcount, vout.hsync, vout.vsync,
                        vout.hblnk, vout.vblnk, dut.frame_ready}), 64'(got.ctl));
        if (got.rgb_known) chk("rgb", 64'(vout.rgb), 64'(got.rgb));
        chk("buffer_select", 64'(dut.buffer_select), 64'(got.bsel));
    endtask

    // mode 0: colour by model buffer parity, mode 1: colour = vcount
    task automatic run_line(input int v, input int mode);
        logic [11:0] pix;
        for (int h = 0; h <= 1055; h++) begin
            pix = (mode == 0) ? (m_bsel ? 12'hBBB : 12'hAAA) : {1'b0, 11'(v)};
            cyc(h, v, pix, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int errs_a;
        int errs_b;
        for (int i = 0; i < 800; i++) begin
            vA[i] = 1'b0;
            vB[i] = 1'b0;
        end
        vin.hsync = 1'b0;
        vin.vsync = 1'b0;
        vin.hblnk = 1'b0;
        vin.vblnk = 1'b0;

        for (int i = 0; i < 10; i++) cyc(0, 0, 12'h000, 1'b1);

        for (int v = 0; v < 4; v++) run_line(v, 0);
        errs_a = 0;
        errs_b = 0;
        for (int i = 0; i < 800; i++) begin
            if (dut.line_buffer_A[i] !== 12'hAAA) errs_a++;
            if (dut.line_buffer_B[i] !== 12'hBBB) errs_b++;
        end
        chk("bufA_bad_entries", 64'(errs_a), 64'd0);
        chk("bufB_bad_entries", 64'(errs_b), 64'd0);

        for (int v = 4; v <= 10; v++) run_line(v, 1);
        for (int v = 597; v <= 606; v++) run_line(v, 1);
        for (int v = 625; v <= 627; v++) run_line(v, 1);
        for (int v = 0; v <= 2; v++) run_line(v, 1);

        run_line(299, 1);
        for (int h = 0; h < 400; h++) cyc(h, 300, 12'(300), 1'b0);
        cyc(400, 300, 12'(300), 1'b1);
        for (int v = 0; v <= 3; v++) run_line(v, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
